// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture block: glyph patterns ({s6..s0},
// active-low), special nibble codes and the frame FSM encoding.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h08;
  localparam logic [6:0] GLYPH_1     = 7'h6D;
  localparam logic [6:0] GLYPH_2     = 7'h22;
  localparam logic [6:0] GLYPH_3     = 7'h24;
  localparam logic [6:0] GLYPH_4     = 7'h45;
  localparam logic [6:0] GLYPH_5     = 7'h14;
  localparam logic [6:0] GLYPH_6     = 7'h10;
  localparam logic [6:0] GLYPH_7     = 7'h2D;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h04;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] ERR   = 4'hE;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph decoder: active-low segment pattern to BCD nibble.
// Unknown patterns decode to ERR with the error flag set.
import seg7_pkg::*;

module seg7_to_bcd (
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = ERR;
    err_o    = 1'b0;
    case (pattern_i)
      GLYPH_0:     nibble_o = 4'h0;
      GLYPH_1:     nibble_o = 4'h1;
      GLYPH_2:     nibble_o = 4'h2;
      GLYPH_3:     nibble_o = 4'h3;
      GLYPH_4:     nibble_o = 4'h4;
      GLYPH_5:     nibble_o = 4'h5;
      GLYPH_6:     nibble_o = 4'h6;
      GLYPH_7:     nibble_o = 4'h7;
      GLYPH_8:     nibble_o = 4'h8;
      GLYPH_9:     nibble_o = 4'h9;
      GLYPH_BLANK: nibble_o = BLANK;
      default:     err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Snoops a multiplexed 4-digit 7-segment display bus, debounces each digit
// and hands complete frames to a consumer over a valid/ready handshake.
import seg7_pkg::*;

module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic [3:0]  digit_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun
);

  // Commit fires on the equal-comparison that makes the run STABLE_CYCLES long.
  localparam logic [7:0] COMMIT_AT = 8'(STABLE_CYCLES - 2);

  logic [10:0] sample_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  slot_nib_q [4];
  logic [3:0]  slot_nib_d [4];
  logic [3:0]  slot_err_q, slot_err_d;
  logic [3:0]  seen_q, seen_d;
  logic [3:0]  hit;
  logic [15:0] bcd_q;
  logic [3:0]  digit_err_q;
  logic        out_valid_q, overrun_q;
  state_e      state_q;

  logic [3:0]  sample_an;
  logic [6:0]  sample_seg;
  logic        addressable, same, commit, frame_done, handshake;
  logic [3:0]  dec_nib;
  logic        dec_err;
  logic [15:0] frame_bcd;

  assign sample_an   = sample_q[10:7];
  assign sample_seg  = sample_q[6:0];
  assign addressable = sample_an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  assign same        = (sample_q == prev_q);
  assign commit      = addressable && same && (cnt_q == COMMIT_AT);
  assign handshake   = out_valid_q && out_ready;

  always_comb begin
    cnt_d = 8'd0;
    if (addressable && same)
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  seg7_to_bcd u_dec (
    .pattern_i (sample_seg),
    .nibble_o  (dec_nib),
    .err_o     (dec_err)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      assign hit[gi]        = commit && !sample_an[gi];
      assign seen_d[gi]     = seen_q[gi] | hit[gi];
      assign slot_nib_d[gi] = hit[gi] ? dec_nib : slot_nib_q[gi];
      assign slot_err_d[gi] = hit[gi] ? dec_err : slot_err_q[gi];
    end
  endgenerate

  // Frame completion looks at this cycle's commit too, so a 4th commit and a
  // handshake landing together are resolved in the same edge.
  assign frame_done = &seen_d;
  assign frame_bcd  = {slot_nib_d[3], slot_nib_d[2], slot_nib_d[1], slot_nib_d[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q    <= '1;
      prev_q      <= '1;
      cnt_q       <= 8'd0;
      slot_nib_q  <= '{default: 4'h0};
      slot_err_q  <= 4'h0;
      seen_q      <= 4'h0;
      bcd_q       <= 16'h0000;
      digit_err_q <= 4'h0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      state_q     <= SCAN;
    end else begin
      sample_q   <= {an, seg};
      prev_q     <= sample_q;
      cnt_q      <= cnt_d;
      slot_nib_q <= slot_nib_d;
      slot_err_q <= slot_err_d;
      seen_q     <= seen_d;
      case (state_q)
        SCAN: begin
          if (frame_done) begin
            bcd_q       <= frame_bcd;
            digit_err_q <= slot_err_d;
            out_valid_q <= 1'b1;
            seen_q      <= 4'h0;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            if (frame_done) begin
              bcd_q       <= frame_bcd;
              digit_err_q <= slot_err_d;
              seen_q      <= 4'h0;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= SCAN;
            end
          end else if (frame_done) begin
            overrun_q <= 1'b1;
            seen_q    <= 4'h0;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign digit_err = digit_err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: scans digit frames on the snooped bus and
// checks debounce, decode, handshake, overrun and reset behaviour.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] bcd;
  logic [3:0]  digit_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overrun;

  int checks = 0;
  int passes = 0;
  int hs_cnt = 0;
  int rise_cnt = 0;
  logic [15:0] hs_bcd = 16'h0;
  logic [3:0]  hs_err = 4'h0;
  logic        prev_valid = 1'b0;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .an        (an),
    .bcd       (bcd),
    .digit_err (digit_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Handshake monitor on the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cnt = hs_cnt + 1;
      hs_bcd = bcd;
      hs_err = digit_err;
      $display("handshake #%0d: bcd=%h digit_err=%b", hs_cnt, bcd, digit_err);
    end
    if (out_valid && !prev_valid) rise_cnt = rise_cnt + 1;
    prev_valid = out_valid;
  end

  // Inputs change 1 time unit after a rising edge; value is seen at n edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic frame(input logic [6:0] p3, input logic [6:0] p2,
                       input logic [6:0] p1, input logic [6:0] p0);
    drive(4'b0111, p3, 8);
    drive(4'b1011, p2, 8);
    drive(4'b1101, p1, 8);
    drive(4'b1110, p0, 8);
    idle(3);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else begin
      passes++;
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an = 4'h0;
    seg = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bcd, digit_err, out_valid, overrun} !== 22'h0) $display("FAIL reset_outputs: got bcd=%h err=%b v=%b ov=%b expected all zero", bcd, digit_err, out_valid, overrun);
    else passes++;
    checks++;
    if (dut.seen_q !== 4'h0) $display("FAIL reset_seen: got %b expected 0000", dut.seen_q);
    else passes++;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_scan();
    int h0, r0;
    out_ready = 1'b1;
    h0 = hs_cnt;
    r0 = rise_cnt;
    frame(7'h24, 7'h22, 7'h6D, 7'h08);
    idle(3);
    checks++;
    if (hs_cnt - h0 !== 1) $display("FAIL scan_handshakes: got %0d expected 1", hs_cnt - h0);
    else passes++;
    checks++;
    if (rise_cnt - r0 !== 1) $display("FAIL scan_valid_pulses: got %0d expected 1", rise_cnt - r0);
    else passes++;
    checks++;
    if (hs_bcd !== 16'h3210) $display("FAIL scan_bcd: got %h expected 3210", hs_bcd);
    else passes++;
    checks++;
    if (hs_err !== 4'h0) $display("FAIL scan_err: got %b expected 0000", hs_err);
    else passes++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL scan_valid_drop: got %b expected 0", out_valid);
    else passes++;
  endtask

  task automatic test_stability();
    drive(4'b1110, 7'h2D, 3);
    idle(2);
    checks++;
    if (dut.seen_q !== 4'b0000) $display("FAIL short_hold_seen: got %b expected 0000", dut.seen_q);
    else passes++;
    drive(4'b1110, 7'h2D, 4);
    idle(2);
    checks++;
    if (dut.seen_q !== 4'b0001) $display("FAIL full_hold_seen: got %b expected 0001", dut.seen_q);
    else passes++;
    drive(4'b0111, 7'h08, 6);
    drive(4'b1011, 7'h08, 6);
    drive(4'b1101, 7'h08, 6);
    idle(5);
    checks++;
    if (hs_bcd !== 16'h0007) $display("FAIL stable_frame_bcd: got %h expected 0007", hs_bcd);
    else passes++;
  endtask

  task automatic test_glyphs();
    frame(7'h45, 7'h7F, 7'h55, 7'h14);
    idle(3);
    checks++;
    if (hs_bcd !== 16'h4FE5) $display("FAIL glyph_bcd: got %h expected 4fe5", hs_bcd);
    else passes++;
    checks++;
    if (hs_err !== 4'b0010) $display("FAIL glyph_err: got %b expected 0010", hs_err);
    else passes++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    frame(7'h6D, 7'h08, 7'h14, 7'h45);
    chk("b2b_first_bcd", bcd, 16'h1054);
    drive(4'b0111, 7'h10, 8);
    drive(4'b1011, 7'h04, 8);
    drive(4'b1101, 7'h2D, 8);
    // Fourth commit lands on the 5th edge; hand shake on exactly that edge.
    drive(4'b1110, 7'h00, 4);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_prev_handshake", hs_bcd, 16'h1054);
    chk("b2b_valid_kept", {15'h0, out_valid}, 16'h1);
    chk("b2b_new_bcd", bcd, 16'h6978);
    chk("b2b_no_overrun", {15'h0, overrun}, 16'h0);
    drive(4'b1110, 7'h00, 3);
    idle(2);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_second_handshake", hs_bcd, 16'h6978);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    frame(7'h6D, 7'h22, 7'h24, 7'h45);
    chk("ovr_first_valid", {15'h0, out_valid}, 16'h1);
    chk("ovr_first_bcd", bcd, 16'h1234);
    chk("ovr_not_yet", {15'h0, overrun}, 16'h0);
    frame(7'h14, 7'h10, 7'h2D, 7'h00);
    chk("ovr_set", {15'h0, overrun}, 16'h1);
    chk("ovr_bcd_held", bcd, 16'h1234);
    chk("ovr_valid_held", {15'h0, out_valid}, 16'h1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idle(2);
    chk("ovr_handshake_bcd", hs_bcd, 16'h1234);
    chk("ovr_valid_dropped", {15'h0, out_valid}, 16'h0);
    chk("ovr_sticky", {15'h0, overrun}, 16'h1);
  endtask

  task automatic test_bad_enable();
    drive(4'b0011, 7'h24, 20);
    drive(4'b1111, 7'h24, 20);
    drive(4'b0000, 7'h08, 20);
    chk("bad_an_seen", {12'h0, dut.seen_q}, 16'h0);
    chk("bad_an_valid", {15'h0, out_valid}, 16'h0);
  endtask

  task automatic test_reset_mid_frame();
    int h0;
    out_ready = 1'b1;
    drive(4'b0111, 7'h04, 6);
    drive(4'b1011, 7'h00, 6);
    idle(2);
    chk("mid_seen_before", {12'h0, dut.seen_q}, 16'h000C);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_bcd", bcd, 16'h0000);
    chk("mid_rst_err", {12'h0, digit_err}, 16'h0);
    chk("mid_rst_flags", {14'h0, out_valid, overrun}, 16'h0);
    rst_n = 1'b1;
    h0 = hs_cnt;
    drive(4'b1101, 7'h2D, 6);
    drive(4'b1110, 7'h10, 6);
    idle(4);
    chk("mid_no_frame", 16'(hs_cnt - h0), 16'h0);
    drive(4'b0111, 7'h45, 6);
    drive(4'b1011, 7'h14, 6);
    idle(4);
    chk("mid_frame_count", 16'(hs_cnt - h0), 16'h1);
    chk("mid_frame_bcd", hs_bcd, 16'h4576);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_stability();
    test_glyphs();
    test_back_to_back();
    test_overrun();
    test_bad_enable();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive equal samples required before a digit is committed (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 SHALL have port seg, input, 7, active-low segment lines, with seg[0]=s0 … seg[6]=s6.
REQ-005 SHALL have port an, input, 4, active-low digit enables; an[i]=0 selects digit i, where digit 3 is the most significant.
REQ-006 SHALL have port bcd, output, 16: captured frame as packed nibbles, digit 3 in [15:12].
REQ-007 SHALL have port digit_err, output, 4: per digit, 1 means the pattern was not a legal glyph.
REQ-008 SHALL have port out_valid, output, 1: a frame is available on bcd/digit_err.
REQ-009 SHALL have port out_ready, input, 1: the consumer accepts the frame.
REQ-010 SHALL have port overrun, output, 1: sticky flag meaning a completed frame was dropped.

Function
REQ-011 SHALL register {an,seg} into a sample register each cycle; all decisions SHALL use the registered sample.
REQ-012 SHALL treat a sample as addressable only if an has exactly one bit low; otherwise the stability counter is cleared and no commit occurs.
REQ-013 SHALL clear the stability counter whenever the sample differs from the previous sample, and otherwise increment it, saturating.
REQ-014 SHALL commit exactly once, on the cycle in which the sample has been equal for STABLE_CYCLES consecutive cycles; there is no further commit until the sample changes.
REQ-015 SHALL decode a commit per the following table (hex of {s6..s0}): 08->0, 6D->1, 22->2, 24->3, 45->4, 14->5, 10->6, 2D->7, 00->8, 04->9, 7F->F (blank, err=0).
REQ-016 SHALL, for any other pattern, store nibble E and set the slot's err bit to 1.
REQ-017 SHALL, on commit, write the nibble and err bit into the slot addressed by an and set that slot's seen bit; a re-commit to a seen slot overwrites it.
REQ-018 SHALL implement FSM SCAN / HOLD, with reset state SCAN.
REQ-019 In SCAN, when all 4 seen bits are set, the block SHALL copy the slots to bcd/digit_err, assert out_valid on the next edge, clear seen, and enter HOLD.
REQ-020 In HOLD, bcd, digit_err and out_valid SHALL stay stable until a cycle with out_valid&&out_ready; at that point out_valid drops on the next edge and the FSM returns to SCAN.
REQ-021 In HOLD, slot collection SHALL continue; if all 4 seen bits become set before the handshake, the block SHALL set overrun, clear seen, drop that frame, and leave the outputs unchanged.
REQ-022 When a handshake and a 4th commit occur in the same cycle in HOLD, the handshake SHALL win, the new frame SHALL be loaded, and out_valid SHALL remain 1.
REQ-023 SHALL clear overrun only on reset.

Reset
REQ-024 SHALL, on rst_n=0 at a clock edge, set bcd=16'h0000, digit_err=4'h0, out_valid=0, overrun=0, seen=0, counter=0, sample=all ones, FSM=SCAN.
REQ-025 SHALL, on reset mid-frame, discard partial slots; no frame is emitted until 4 fresh commits occur after reset release.

Structure
REQ-026 SHALL place the glyph pattern constants, the BLANK=4'hF and ERR=4'hE codes, and the FSM state encodings in shared package seg7_pkg.
REQ-027 SHALL instantiate a combinational sub-module seg7_to_bcd (7-bit pattern in; nibble and err out); all sequential logic stays in seg7_capture.

Verification
REQ-028 Scan digits 3..0 with patterns 24, 22, 6D, 08, each held 8 cycles, out_ready=1 -> bcd=16'h3210, digit_err=0, one out_valid pulse.
REQ-029 Present digit 0 with pattern 2D held for only 3 cycles (STABLE_CYCLES=4) -> no commit; hold it 4 cycles -> commit of 7.
REQ-030 Present pattern 7F on digit 2 and pattern 55 on digit 1 -> nibbles F and E, digit_err=4'b0010.
REQ-031 Keep out_ready=0 while two complete frames scan -> first frame held stable, overrun=1 from the second completion onward.
REQ-032 Present an=4'b0011 or 4'b1111 for 20 cycles -> no commits, seen stays 0.
REQ-033 Assert rst_n=0 after 2 of 4 digits are committed -> all outputs at reset values; the next frame requires 4 new commits.
